// File: rtl/mdio_pkg.sv
// Shared MDIO Clause-22 definitions: frame fields, FSM states
// and the frame builder used by the arbiter and the controller.
package mdio_pkg;

    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA       = 2'b10;

    localparam int BMSR_LINK_BIT = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic {
        G_POLL = 1'b0,
        G_HOST = 1'b1
    } grant_t;

    function automatic logic [31:0] build_frame(
        input logic [1:0]  op,
        input logic [4:0]  phy,
        input logic [4:0]  regad,
        input logic [15:0] data
    );
        return {ST, op, phy, regad, TA, data};
    endfunction

endpackage

// File: rtl/mdio_poll_timer.sv
// Auto-poll period timer: fires at count 0, reloads, and keeps a
// single pending flag that the arbiter clears when it grants the poll.
module mdio_poll_timer #(
    parameter int POLL_PERIOD = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic grant_clr,
    output logic fire,
    output logic pend
);

    localparam int CW = $clog2(POLL_PERIOD + 1);
    localparam logic [CW-1:0] RELOAD = CW'(POLL_PERIOD - 1);

    logic [CW-1:0] cnt;

    assign fire = en && (cnt == '0);

    // Down-count while enabled; a grant consumes the pending request,
    // and an expiry while already pending does not queue a second one.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            cnt <= fire ? RELOAD : cnt - CW'(1);
            if (grant_clr) begin
                pend <= 1'b0;
            end else if (fire) begin
                pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdio_arbiter.sv
// Shares one MDIO controller between the host register port and the
// PHY status auto-poller; builds frames and returns read data.
module mdio_arbiter
    import mdio_pkg::*;
#(
    parameter int         POLL_PERIOD = 1000,
    parameter logic [4:0] POLL_PHY    = 5'd1,
    parameter logic [4:0] POLL_REG    = 5'd1,
    parameter int         TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_req,
    input  logic        host_write,
    input  logic [4:0]  host_phy,
    input  logic [4:0]  host_reg,
    input  logic [15:0] host_wdata,
    output logic        host_busy,
    output logic        host_done,
    output logic        host_err,
    output logic [15:0] host_rdata,
    input  logic        poll_en,
    output logic [15:0] poll_status,
    output logic        poll_valid,
    output logic        link_change,
    output logic        mdio_start,
    output logic [31:0] t_data,
    input  logic        ctrl_done,
    input  logic [15:0] ctrl_rd_data
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    state_t state, state_nx;
    grant_t gnt, last_grant;

    logic           host_pend;
    logic           h_write;
    logic [4:0]     h_phy;
    logic [4:0]     h_reg;
    logic [15:0]    h_wdata;
    logic [WCW-1:0] wait_cnt;

    logic        host_acc;
    logic        host_want;
    logic        poll_fire;
    logic        poll_pend;
    logic        poll_want;
    logic        grant_vld;
    logic        grant_host;
    logic        done_ok;
    logic        done_err;
    logic        cur_write;
    logic [4:0]  cur_phy;
    logic [4:0]  cur_reg;
    logic [15:0] cur_wdata;
    logic [31:0] host_frame;
    logic [31:0] poll_frame;

    assign host_acc  = host_req && !host_busy;
    assign host_want = host_pend || host_acc;
    assign poll_want = poll_pend || poll_fire;

    // A request accepted this cycle can be granted before its fields
    // land in the capture registers, so take them straight from the port.
    assign cur_write = host_acc ? host_write : h_write;
    assign cur_phy   = host_acc ? host_phy   : h_phy;
    assign cur_reg   = host_acc ? host_reg   : h_reg;
    assign cur_wdata = host_acc ? host_wdata : h_wdata;

    assign host_frame = build_frame(cur_write ? OP_WRITE : OP_READ,
                                    cur_phy, cur_reg,
                                    cur_write ? cur_wdata : 16'h0000);
    assign poll_frame = build_frame(OP_READ, POLL_PHY, POLL_REG, 16'h0000);

    assign mdio_start = (state == S_START);

    mdio_poll_timer #(
        .POLL_PERIOD(POLL_PERIOD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (poll_en),
        .grant_clr(grant_vld && !grant_host),
        .fire     (poll_fire),
        .pend     (poll_pend)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, round-robin grant on ties, completion decode.
    always_comb begin
        state_nx   = state;
        grant_vld  = 1'b0;
        grant_host = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (host_want && poll_want) begin
                    grant_vld  = 1'b1;
                    grant_host = (last_grant == G_POLL);
                end else if (host_want || poll_want) begin
                    grant_vld  = 1'b1;
                    grant_host = host_want;
                end
                if (grant_vld) begin
                    state_nx = S_START;
                end
            end
            S_START: state_nx = S_WAIT;
            S_WAIT: begin
                if (ctrl_done) begin
                    done_ok  = 1'b1;
                    state_nx = S_DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    done_err = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Request capture, frame register, wait counter and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            host_busy   <= 1'b0;
            host_pend   <= 1'b0;
            h_write     <= 1'b0;
            h_phy       <= '0;
            h_reg       <= '0;
            h_wdata     <= '0;
            gnt         <= G_POLL;
            last_grant  <= G_POLL;
            t_data      <= '0;
            wait_cnt    <= '0;
            host_done   <= 1'b0;
            host_err    <= 1'b0;
            host_rdata  <= '0;
            poll_status <= '0;
            poll_valid  <= 1'b0;
            link_change <= 1'b0;
        end else begin
            host_done   <= 1'b0;
            host_err    <= 1'b0;
            poll_valid  <= 1'b0;
            link_change <= 1'b0;

            if (state == S_DONE && gnt == G_HOST) begin
                host_busy <= 1'b0;
            end

            if (host_acc) begin
                host_busy <= 1'b1;
                h_write   <= host_write;
                h_phy     <= host_phy;
                h_reg     <= host_reg;
                h_wdata   <= host_wdata;
                host_pend <= !(grant_vld && grant_host);
            end else if (grant_vld && grant_host) begin
                host_pend <= 1'b0;
            end

            if (grant_vld) begin
                t_data     <= grant_host ? host_frame : poll_frame;
                gnt        <= grant_host ? G_HOST : G_POLL;
                last_grant <= grant_host ? G_HOST : G_POLL;
            end

            if (state == S_START) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end

            if (done_ok || done_err) begin
                if (gnt == G_HOST) begin
                    host_done <= 1'b1;
                    host_err  <= done_err;
                    if (done_err) begin
                        host_rdata <= 16'hFFFF;
                    end else if (!h_write) begin
                        host_rdata <= ctrl_rd_data;
                    end
                end else if (done_ok) begin
                    poll_status <= ctrl_rd_data;
                    poll_valid  <= 1'b1;
                    link_change <= ctrl_rd_data[BMSR_LINK_BIT]
                                 ^ poll_status[BMSR_LINK_BIT];
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed self-checking bench for mdio_arbiter.
// Frames: {01, op, phy, reg, 10, data}.
module tb_mdio_arbiter;

    localparam int PP = 20;
    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_req;
    logic        host_write;
    logic [4:0]  host_phy;
    logic [4:0]  host_reg;
    logic [15:0] host_wdata;
    logic        host_busy;
    logic        host_done;
    logic        host_err;
    logic [15:0] host_rdata;
    logic        poll_en;
    logic [15:0] poll_status;
    logic        poll_valid;
    logic        link_change;
    logic        mdio_start;
    logic [31:0] t_data;
    logic        ctrl_done;
    logic [15:0] ctrl_rd_data;

    int passes = 0;
    int total  = 0;
    int n;

    mdio_arbiter #(
        .POLL_PERIOD(PP),
        .POLL_PHY   (5'd1),
        .POLL_REG   (5'd1),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host_req    (host_req),
        .host_write  (host_write),
        .host_phy    (host_phy),
        .host_reg    (host_reg),
        .host_wdata  (host_wdata),
        .host_busy   (host_busy),
        .host_done   (host_done),
        .host_err    (host_err),
        .host_rdata  (host_rdata),
        .poll_en     (poll_en),
        .poll_status (poll_status),
        .poll_valid  (poll_valid),
        .link_change (link_change),
        .mdio_start  (mdio_start),
        .t_data      (t_data),
        .ctrl_done   (ctrl_done),
        .ctrl_rd_data(ctrl_rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic req(input logic w, input logic [4:0] p,
                       input logic [4:0] r, input logic [15:0] d);
        host_req   = 1'b1;
        host_write = w;
        host_phy   = p;
        host_reg   = r;
        host_wdata = d;
    endtask

    initial begin
        reset        = 1'b1;
        host_req     = 1'b0;
        host_write   = 1'b0;
        host_phy     = '0;
        host_reg     = '0;
        host_wdata   = '0;
        poll_en      = 1'b0;
        ctrl_done    = 1'b0;
        ctrl_rd_data = '0;
        tick();
        tick();
        chk("rst_busy", 32'(host_busy), 32'd0);
        chk("rst_tdata", t_data, 32'h0);
        chk("rst_start", 32'(mdio_start), 32'd0);
        chk("rst_pstat", 32'(poll_status), 32'h0);
        chk("rst_rdata", 32'(host_rdata), 32'h0);
        reset = 1'b0;
        tick();

        // host write phy=3 reg=0
        req(1'b1, 5'd3, 5'd0, 16'h1140);
        tick();
        host_req = 1'b0;
        chk("wr_start", 32'(mdio_start), 32'd1);
        chk("wr_busy", 32'(host_busy), 32'd1);
        chk("wr_tdata", t_data, 32'h5182_1140);
        tick();
        chk("wr_start_once", 32'(mdio_start), 32'd0);
        tick();
        chk("wr_tdata_hold", t_data, 32'h5182_1140);
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        chk("wr_done", 32'(host_done), 32'd1);
        chk("wr_err", 32'(host_err), 32'd0);
        tick();
        chk("wr_done_pulse", 32'(host_done), 32'd0);
        chk("wr_busy_fall", 32'(host_busy), 32'd0);

        // host read phy=1 reg=2
        req(1'b0, 5'd1, 5'd2, 16'hBEEF);
        tick();
        host_req = 1'b0;
        chk("rd_tdata", t_data, 32'h608A_0000);
        tick();
        tick();
        ctrl_done    = 1'b1;
        ctrl_rd_data = 16'h0141;
        tick();
        ctrl_done = 1'b0;
        chk("rd_done", 32'(host_done), 32'd1);
        chk("rd_rdata", 32'(host_rdata), 32'h0141);
        tick();

        // timeout
        req(1'b0, 5'd1, 5'd2, 16'h0);
        tick();
        host_req = 1'b0;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        chk("to_early", 32'(host_done), 32'd0);
        tick();
        chk("to_done", 32'(host_done), 32'd1);
        chk("to_err", 32'(host_err), 32'd1);
        chk("to_rdata", 32'(host_rdata), 32'hFFFF);
        tick();
        chk("to_idle_busy", 32'(host_busy), 32'd0);

        // auto-poll: fires on enable, then every PP cycles
        poll_en = 1'b1;
        tick();
        chk("p1_start", 32'(mdio_start), 32'd1);
        chk("p1_tdata", t_data, 32'h6086_0000);
        tick();
        ctrl_done    = 1'b1;
        ctrl_rd_data = 16'h0004;
        tick();
        ctrl_done = 1'b0;
        chk("p1_valid", 32'(poll_valid), 32'd1);
        chk("p1_status", 32'(poll_status), 32'h0004);
        chk("p1_link", 32'(link_change), 32'd1);
        chk("p1_nohost", 32'(host_done), 32'd0);
        tick();
        chk("p1_valid_pulse", 32'(poll_valid), 32'd0);
        n = 0;
        while (!mdio_start && n < 40) begin
            tick();
            n++;
        end
        chk("p2_period", 32'(n), 32'd17);
        tick();
        ctrl_done    = 1'b1;
        ctrl_rd_data = 16'h0000;
        tick();
        ctrl_done = 1'b0;
        chk("p2_valid", 32'(poll_valid), 32'd1);
        chk("p2_link", 32'(link_change), 32'd1);
        chk("p2_status", 32'(poll_status), 32'h0000);
        tick();
        n = 0;
        while (!mdio_start && n < 40) begin
            tick();
            n++;
        end
        chk("p3_period", 32'(n), 32'd17);
        tick();
        ctrl_done    = 1'b1;
        ctrl_rd_data = 16'h7809;
        tick();
        ctrl_done = 1'b0;
        chk("p3_link", 32'(link_change), 32'd0);
        chk("p3_status", 32'(poll_status), 32'h7809);
        poll_en = 1'b0;
        tick();
        tick();

        // tie: host req and poll expiry in the same cycle
        poll_en = 1'b1;
        req(1'b1, 5'd3, 5'd0, 16'h1140);
        tick();
        host_req = 1'b0;
        chk("tie1_host", t_data, 32'h5182_1140);
        tick();
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        chk("tie1_hdone", 32'(host_done), 32'd1);
        tick();
        // new host req meets the pending poll; poll's turn now
        req(1'b0, 5'd2, 5'd3, 16'h0);
        tick();
        host_req = 1'b0;
        chk("tie2_poll", t_data, 32'h6086_0000);
        chk("tie2_hbusy", 32'(host_busy), 32'd1);
        tick();
        ctrl_done    = 1'b1;
        ctrl_rd_data = 16'h0004;
        tick();
        ctrl_done = 1'b0;
        chk("tie2_pvalid", 32'(poll_valid), 32'd1);
        tick();
        tick();
        chk("tie3_host", t_data, 32'h610E_0000);
        chk("tie3_start", 32'(mdio_start), 32'd1);
        poll_en = 1'b0;
        tick();
        ctrl_done    = 1'b1;
        ctrl_rd_data = 16'h1234;
        tick();
        ctrl_done = 1'b0;
        chk("tie3_rdata", 32'(host_rdata), 32'h1234);
        tick();

        // reset in WAIT; late ctrl_done ignored
        req(1'b0, 5'd1, 5'd2, 16'h0);
        tick();
        host_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_busy", 32'(host_busy), 32'd0);
        chk("mr_tdata", t_data, 32'h0);
        chk("mr_rdata", 32'(host_rdata), 32'h0);
        chk("mr_pstat", 32'(poll_status), 32'h0);
        chk("mr_start", 32'(mdio_start), 32'd0);
        ctrl_done    = 1'b1;
        ctrl_rd_data = 16'hAAAA;
        tick();
        ctrl_done = 1'b0;
        chk("late_hdone", 32'(host_done), 32'd0);
        chk("late_pvalid", 32'(poll_valid), 32'd0);
        chk("late_rdata", 32'(host_rdata), 32'h0);
        tick();
        chk("late_start", 32'(mdio_start), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
